// File: rtl/tagged_msg_pkg.sv
// Shared types for the tagged-union message link: tag encoding, the packed
// message layout, per-tag payload length and the receiver state encoding.
package tagged_msg_pkg;

  // Longest payload any tag can carry (TAG_LONG).
  localparam int LONG_BYTES = 8;

  // Payload width of the reference message layout.
  localparam int MSG_PAYLOAD_BYTES = 8;

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_BYTE = 2'd1,
    TAG_INT  = 2'd2,
    TAG_LONG = 2'd3
  } tag_e;

  typedef struct packed {
    tag_e                             tag;
    logic [8*MSG_PAYLOAD_BYTES-1:0]   payload;
  } msg_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_CHECK   = 2'd2,
    ST_HOLD    = 2'd3
  } state_e;

  // Number of payload bytes that follow a tag byte.
  function automatic logic [3:0] payload_len(input tag_e tag);
    case (tag)
      TAG_NONE: payload_len = 4'd0;
      TAG_BYTE: payload_len = 4'd1;
      TAG_INT:  payload_len = 4'd4;
      default:  payload_len = 4'd8;
    endcase
  endfunction

endpackage

// File: rtl/tagged_msg_err_counter.sv
// Saturating counter of dropped frames; advances once per err_pulse cycle
// and sticks at all-ones.
module tagged_msg_err_counter #(
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 err_pulse,
  output logic [ERR_CNT_W-1:0] count
);

  // Count dropped frames, holding at the maximum value.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (err_pulse && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/tagged_msg_deserializer.sv
// Receive side of the tagged-union message link. Rebuilds one packed
// {tag, payload} message from a byte stream, holds it on a valid/ready
// output, and drops/counts malformed frames.
// Optional build macro TAGGED_MSG_CHECKSUM_EN: each frame carries a trailing
// XOR checksum byte that is verified before the message is presented.
module tagged_msg_deserializer
  import tagged_msg_pkg::*;
#(
  parameter int MAX_PAYLOAD_BYTES = 8,
  parameter int ERR_CNT_W         = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [7:0]                     in_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [2+8*MAX_PAYLOAD_BYTES-1:0] out_msg,
  output logic                           err_pulse,
  output logic [ERR_CNT_W-1:0]           err_count
);

`ifdef TAGGED_MSG_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  localparam int PW = 8 * MAX_PAYLOAD_BYTES;

  state_e          state_q, state_d;
  tag_e            tag_q, tag_d;
  logic [PW-1:0]   payload_q, payload_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      csum_q, csum_d;
  logic            err_q, err_d;
  logic            accept;
  logic            tag_accept;
  logic            last_byte;

  assign accept     = in_valid && in_ready;
  // A tag byte arrives either in IDLE or in the HOLD handshake cycle.
  assign tag_accept = accept && ((state_q == ST_IDLE) || (state_q == ST_HOLD));
  assign last_byte  = ({1'b0, idx_q} == (payload_len(tag_q) - 4'd1));

  assign out_valid = (state_q == ST_HOLD);
  assign out_msg   = {tag_q, payload_q};
  assign err_pulse = err_q;

  // Input readiness: always open except while a message waits for its consumer.
  always_comb begin
    in_ready = 1'b1;
    if (state_q == ST_HOLD) begin
      in_ready = out_ready;
    end
  end

  // Next-state and datapath updates for frame assembly.
  // NOTE: every always_comb target gets a default first so no latch is inferred.
  always_comb begin
    state_d   = state_q;
    tag_d     = tag_q;
    payload_d = payload_q;
    idx_d     = idx_q;
    csum_d    = csum_q;
    err_d     = 1'b0;

    case (state_q)
      ST_PAYLOAD: begin
        if (accept) begin
          for (int i = 0; i < LONG_BYTES; i++) begin
            if (idx_q == 3'(i)) begin
              payload_d[8*i +: 8] = in_data;
            end
          end
          csum_d = csum_q ^ in_data;
          idx_d  = idx_q + 3'd1;
          if (last_byte) begin
            state_d = CSUM_EN ? ST_CHECK : ST_HOLD;
          end
        end
      end
      ST_CHECK: begin
        if (accept) begin
          if (in_data == csum_q) begin
            state_d = ST_HOLD;
          end else begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: ;
    endcase

    // Tag byte handling shared by IDLE and the back-to-back HOLD handshake.
    if (tag_accept) begin
      if (in_data[7:2] != 6'd0) begin
        err_d   = 1'b1;
        state_d = ST_IDLE;
      end else begin
        tag_d     = tag_e'(in_data[1:0]);
        payload_d = '0;
        idx_d     = 3'd0;
        csum_d    = in_data;
        if (payload_len(tag_e'(in_data[1:0])) == 4'd0) begin
          state_d = CSUM_EN ? ST_CHECK : ST_HOLD;
        end else begin
          state_d = ST_PAYLOAD;
        end
      end
    end
  end

  // Frame assembly registers; reset discards any partial frame silently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      tag_q     <= TAG_NONE;
      payload_q <= '0;
      idx_q     <= 3'd0;
      csum_q    <= 8'd0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      tag_q     <= tag_d;
      payload_q <= payload_d;
      idx_q     <= idx_d;
      csum_q    <= csum_d;
      err_q     <= err_d;
    end
  end

  tagged_msg_err_counter #(
    .ERR_CNT_W (ERR_CNT_W)
  ) u_err_counter (
    .clk       (clk),
    .rst_n     (rst_n),
    .err_pulse (err_q),
    .count     (err_count)
  );

endmodule

// File: tb/tb_tagged_msg_deserializer.sv
// Self-checking bench for tagged_msg_deserializer: a table of per-cycle
// {inputs, expected outputs} rows plus hand-written backpressure, saturation
// and mid-frame reset sequences. Works with or without TAGGED_MSG_CHECKSUM_EN.
module tb_tagged_msg_deserializer;
  import tagged_msg_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        out_valid;
  logic        out_ready;
  logic [65:0] out_msg;
  logic        err_pulse;
  logic [7:0]  err_count;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic        in_valid;
    logic [7:0]  in_data;
    logic        out_ready;
    logic        exp_in_ready;
    logic        exp_out_valid;
    logic        exp_err;
    logic [65:0] exp_msg;
  } vec_t;

  vec_t vecs[$];

`ifdef TAGGED_MSG_CHECKSUM_EN
  localparam bit CSUM = 1'b1;
  localparam int EXP_ERRS = 2;
`else
  localparam bit CSUM = 1'b0;
  localparam int EXP_ERRS = 1;
`endif

  tagged_msg_deserializer #(
    .MAX_PAYLOAD_BYTES (8),
    .ERR_CNT_W         (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_msg   (out_msg),
    .err_pulse (err_pulse),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  function automatic logic [65:0] msg(input tag_e t, input logic [63:0] p);
    msg_t m;
    m.tag     = t;
    m.payload = p;
    return m;
  endfunction

  function automatic vec_t mk(input logic v, input logic [7:0] d, input logic r,
                              input logic eir, input logic eov, input logic eerr,
                              input logic [65:0] m);
    vec_t x;
    x.in_valid = v;  x.in_data = d;  x.out_ready = r;
    x.exp_in_ready = eir;  x.exp_out_valid = eov;  x.exp_err = eerr;  x.exp_msg = m;
    return x;
  endfunction

  task automatic check(input string name, input logic [65:0] act, input logic [65:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One cycle: drive inputs, check in_ready, clock, check registered outputs.
  task automatic apply(input vec_t v, input string id);
    in_valid  = v.in_valid;
    in_data   = v.in_data;
    out_ready = v.out_ready;
    #1;
    check({id, " in_ready"}, 66'(in_ready), 66'(v.exp_in_ready));
    @(posedge clk);
    #1;
    check({id, " out_valid"}, 66'(out_valid), 66'(v.exp_out_valid));
    check({id, " err_pulse"}, 66'(err_pulse), 66'(v.exp_err));
    if (v.exp_out_valid) check({id, " out_msg"}, out_msg, v.exp_msg);
  endtask

  // Push a complete frame (checksum appended when enabled) with out_ready=1,
  // followed by one idle cycle that consumes the message.
  task automatic add_frame(input logic [7:0] b[$], input logic [65:0] m);
    logic [7:0] x;
    x = 8'h00;
    foreach (b[i]) begin
      x ^= b[i];
      vecs.push_back(mk(1'b1, b[i], 1'b1, 1'b1,
                        (!CSUM && i == b.size() - 1), 1'b0, m));
    end
    if (CSUM) vecs.push_back(mk(1'b1, x, 1'b1, 1'b1, 1'b1, 1'b0, m));
    vecs.push_back(mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, '0));
  endtask

  initial begin
    rst_n = 1'b0;  in_valid = 1'b0;  in_data = 8'h00;  out_ready = 1'b1;
    #1;
    check("reset out_valid", 66'(out_valid), 66'd0);
    check("reset out_msg", out_msg, 66'd0);
    check("reset err_pulse", 66'(err_pulse), 66'd0);
    check("reset err_count", 66'(err_count), 66'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    check("post-reset in_ready", 66'(in_ready), 66'd1);

    // ---------------- table ----------------
    add_frame('{8'h02, 8'h78, 8'h56, 8'h34, 8'h12}, msg(TAG_INT, 64'h12345678));
    if (!CSUM) begin
      // Two TAG_NONE messages back to back; the second tag lands in the handshake.
      vecs.push_back(mk(1'b1, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, msg(TAG_NONE, 64'h0)));
      vecs.push_back(mk(1'b1, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, msg(TAG_NONE, 64'h0)));
      vecs.push_back(mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, '0));
    end else begin
      vecs.push_back(mk(1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, '0));
      vecs.push_back(mk(1'b1, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, msg(TAG_NONE, 64'h0)));
      vecs.push_back(mk(1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, '0));
      vecs.push_back(mk(1'b1, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, msg(TAG_NONE, 64'h0)));
      vecs.push_back(mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, '0));
      // Good checksum then bad checksum on a TAG_BYTE frame.
      vecs.push_back(mk(1'b1, 8'h01, 1'b1, 1'b1, 1'b0, 1'b0, '0));
      vecs.push_back(mk(1'b1, 8'h3C, 1'b1, 1'b1, 1'b0, 1'b0, '0));
      vecs.push_back(mk(1'b1, 8'h3D, 1'b1, 1'b1, 1'b1, 1'b0, msg(TAG_BYTE, 64'h3C)));
      vecs.push_back(mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, '0));
      vecs.push_back(mk(1'b1, 8'h01, 1'b1, 1'b1, 1'b0, 1'b0, '0));
      vecs.push_back(mk(1'b1, 8'h3C, 1'b1, 1'b1, 1'b0, 1'b0, '0));
      vecs.push_back(mk(1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, '0));
      vecs.push_back(mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, '0));
    end
    // Bad tag byte is dropped, the following frame decodes normally.
    vecs.push_back(mk(1'b1, 8'h85, 1'b1, 1'b1, 1'b0, 1'b1, '0));
    add_frame('{8'h01, 8'h5A}, msg(TAG_BYTE, 64'h5A));
    add_frame('{8'h03, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88},
              msg(TAG_LONG, 64'h8877665544332211));

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], $sformatf("row%0d", i));
    check("table err_count", 66'(err_count), 66'(EXP_ERRS));

    // ---------------- backpressure ----------------
    apply(mk(1'b1, 8'h01, 1'b0, 1'b1, 1'b0, 1'b0, '0), "bp tag");
    apply(mk(1'b1, 8'hAB, 1'b0, 1'b1, !CSUM, 1'b0, msg(TAG_BYTE, 64'hAB)), "bp data");
    if (CSUM) apply(mk(1'b1, 8'hAA, 1'b0, 1'b1, 1'b1, 1'b0, msg(TAG_BYTE, 64'hAB)), "bp csum");
    for (int i = 0; i < 5; i++)
      apply(mk(1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, msg(TAG_BYTE, 64'hAB)),
            $sformatf("bp hold%0d", i));
    apply(mk(1'b1, 8'h00, 1'b1, 1'b1, !CSUM, 1'b0, msg(TAG_NONE, 64'h0)), "bp handshake");
    if (CSUM) apply(mk(1'b1, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, msg(TAG_NONE, 64'h0)), "bp next csum");
    apply(mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, '0), "bp drain");

    // ---------------- saturation ----------------
    in_valid = 1'b1;  in_data = 8'hFC;  out_ready = 1'b1;
    repeat (300) @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("sat err_count", 66'(err_count), 66'd255);
    check("sat err_pulse idle", 66'(err_pulse), 66'd0);

    // ---------------- reset mid TAG_LONG frame ----------------
    apply(mk(1'b1, 8'h03, 1'b1, 1'b1, 1'b0, 1'b0, '0), "rst tag");
    apply(mk(1'b1, 8'h11, 1'b1, 1'b1, 1'b0, 1'b0, '0), "rst b0");
    apply(mk(1'b1, 8'h22, 1'b1, 1'b1, 1'b0, 1'b0, '0), "rst b1");
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst out_valid", 66'(out_valid), 66'd0);
    check("midrst out_msg", out_msg, 66'd0);
    check("midrst err_pulse", 66'(err_pulse), 66'd0);
    check("midrst err_count", 66'(err_count), 66'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    vecs.delete();
    add_frame('{8'h03, 8'hF0, 8'hDE, 8'hBC, 8'h9A, 8'h78, 8'h56, 8'h34, 8'h12},
              msg(TAG_LONG, 64'h123456789ABCDEF0));
    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], $sformatf("post-rst row%0d", i));
    check("post-rst err_count", 66'(err_count), 66'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
